// File: rtl/vram_pkg.sv
// Shared VRAM geometry and enum types for the VRAM write path, VGA controller
// and bus decoder.
package vram_pkg;
    localparam int ROW_W  = 80;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 12;
    localparam int X_W    = 7;
    localparam int Y_W    = 6;

    typedef enum logic {IDLE, FILL} fill_state_t;
    typedef enum logic {GNT_CPU, GNT_FILL} grant_t;
endpackage

// File: rtl/vram_write_arbiter_if.sv
// Bus-decoder side request/status signals plus the VRAM port-A write signals.
interface vram_write_arbiter_if import vram_pkg::*; #(
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int DATA_W = vram_pkg::DATA_W
) ();
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic              fill_start;
    logic              fill_abort;
    logic [X_W-1:0]    fill_x0;
    logic [Y_W-1:0]    fill_y0;
    logic [X_W-1:0]    fill_w;
    logic [Y_W-1:0]    fill_h;
    logic [DATA_W-1:0] fill_color;
    logic              fill_busy;
    logic              fill_done;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_din;

    modport master (
        output cpu_we, cpu_addr, cpu_data, fill_start, fill_abort,
               fill_x0, fill_y0, fill_w, fill_h, fill_color,
        input  cpu_ready, fill_busy, fill_done, vram_we, vram_addr, vram_din
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_data, fill_start, fill_abort,
               fill_x0, fill_y0, fill_w, fill_h, fill_color,
        output cpu_ready, fill_busy, fill_done, vram_we, vram_addr, vram_din
    );
endinterface

// File: rtl/rect_walker.sv
// Clips a fill rectangle to the screen and walks its cells in row-major order,
// building each address as row_base + x.
module rect_walker import vram_pkg::*; #(
    parameter int ROW_W  = vram_pkg::ROW_W,
    parameter int ROWS   = vram_pkg::ROWS,
    parameter int ADDR_W = vram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              load,
    input  logic              advance,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              empty
);
    logic [X_W-1:0]    x_room, eff_w;
    logic [Y_W-1:0]    y_room, eff_h;
    logic [X_W-1:0]    x, x_first, x_last;
    logic [Y_W-1:0]    rows_left;
    logic [ADDR_W-1:0] row_base, load_base;

    // Room values wrap when the origin is off-screen; empty masks that case.
    always_comb begin
        x_room    = X_W'(ROW_W) - x0;
        y_room    = Y_W'(ROWS) - y0;
        eff_w     = (w < x_room) ? w : x_room;
        eff_h     = (h < y_room) ? h : y_room;
        empty     = (x0 >= X_W'(ROW_W)) || (y0 >= Y_W'(ROWS)) || (w == '0) || (h == '0);
        load_base = ADDR_W'(y0) * ADDR_W'(ROW_W);
    end

    always_ff @(posedge clk) begin
        if (load) begin
            x         <= x0;
            x_first   <= x0;
            x_last    <= x0 + eff_w - 1'b1;
            rows_left <= eff_h;
            row_base  <= load_base;
        end else if (advance) begin
            if (x == x_last) begin
                x         <= x_first;
                row_base  <= row_base + ADDR_W'(ROW_W);
                rows_left <= rows_left - 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign addr = row_base + ADDR_W'(x);
    assign last = (x == x_last) && (rows_left == Y_W'(1));
endmodule

// File: rtl/vram_write_arbiter.sv
// Shares VRAM port A between a one-entry CPU write buffer and the rectangle
// fill engine, alternating grants when both are pending.
module vram_write_arbiter import vram_pkg::*; #(
    parameter int ROW_W  = vram_pkg::ROW_W,
    parameter int ROWS   = vram_pkg::ROWS,
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int DATA_W = vram_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    vram_write_arbiter_if.slave  bus
);
    fill_state_t       state, state_next;
    grant_t            last_grant;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] fill_color_q;
    logic              cpu_req, fill_req, gnt_cpu, gnt_fill;
    logic              walk_load, fill_done_next;
    logic [ADDR_W-1:0] walk_addr;
    logic              walk_last, walk_empty;

    rect_walker #(.ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_walker (
        .clk     (clk),
        .load    (walk_load),
        .advance (gnt_fill),
        .x0      (bus.fill_x0),
        .y0      (bus.fill_y0),
        .w       (bus.fill_w),
        .h       (bus.fill_h),
        .addr    (walk_addr),
        .last    (walk_last),
        .empty   (walk_empty)
    );

    assign bus.cpu_ready = !buf_valid;
    assign bus.fill_busy = (state == FILL);

    // An abort suppresses the fill request so no write slips out on that edge.
    always_comb begin
        state_next     = state;
        walk_load      = 1'b0;
        fill_done_next = 1'b0;
        cpu_req        = buf_valid;
        fill_req       = (state == FILL) && !bus.fill_abort;
        gnt_cpu        = cpu_req && (!fill_req || (last_grant == GNT_FILL));
        gnt_fill       = fill_req && !gnt_cpu;
        case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    walk_load = 1'b1;
                    if (walk_empty) fill_done_next = 1'b1;
                    else            state_next     = FILL;
                end
            end
            FILL: begin
                if (bus.fill_abort) begin
                    state_next = IDLE;
                end else if (gnt_fill && walk_last) begin
                    state_next     = IDLE;
                    fill_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_valid     <= 1'b0;
            last_grant    <= GNT_FILL;
            bus.fill_done <= 1'b0;
            bus.vram_we   <= 1'b0;
            bus.vram_addr <= '0;
            bus.vram_din  <= '0;
        end else begin
            if (gnt_cpu)         buf_valid <= 1'b0;
            else if (bus.cpu_we) buf_valid <= 1'b1;
            if (gnt_cpu)       last_grant <= GNT_CPU;
            else if (gnt_fill) last_grant <= GNT_FILL;
            bus.fill_done <= fill_done_next;
            bus.vram_we   <= gnt_cpu || gnt_fill;
            if (gnt_cpu) begin
                bus.vram_addr <= buf_addr;
                bus.vram_din  <= buf_data;
            end else if (gnt_fill) begin
                bus.vram_addr <= walk_addr;
                bus.vram_din  <= fill_color_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cpu_we && !buf_valid) begin
            buf_addr <= bus.cpu_addr;
            buf_data <= bus.cpu_data;
        end
        if (walk_load) fill_color_q <= bus.fill_color;
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: CPU path, clipping, contention,
// empty fills, abort with dropped CPU write, and asynchronous reset.
module tb_vram_write_arbiter;
    import vram_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [12:0] wr_addr[$];
    logic [11:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];

    vram_write_arbiter_if bus_if ();

    vram_write_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.vram_we) begin
            wr_addr.push_back(bus_if.vram_addr);
            wr_data.push_back(bus_if.vram_din);
            wr_cyc.push_back(cyc);
        end
        if (bus_if.fill_done) done_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fill(input int x0, input int y0, input int w, input int h, input int color);
        bus_if.fill_x0    = 7'(x0);
        bus_if.fill_y0    = 6'(y0);
        bus_if.fill_w     = 7'(w);
        bus_if.fill_h     = 6'(h);
        bus_if.fill_color = 12'(color);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        total++; if (bus_if.cpu_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus_if.cpu_ready); end
        total++; if (bus_if.fill_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_if.fill_busy); end
        total++; if (bus_if.fill_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus_if.fill_done); end
        total++; if (bus_if.vram_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus_if.vram_we); end
        total++; if (bus_if.vram_addr !== 13'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus_if.vram_addr); end
        total++; if (bus_if.vram_din !== 12'h0) begin bad++; $display("FAIL rst_din: got %h want 0", bus_if.vram_din); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        total++; if (bus_if.vram_we !== 1'b0 || bus_if.cpu_ready !== 1'b1) begin bad++; $display("FAIL rst_idle: got we=%b ready=%b want 0/1", bus_if.vram_we, bus_if.cpu_ready); end
    endtask

    task automatic test_cpu_single();
        bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 13'h0100; bus_if.cpu_data = 12'hF00;
        tick();
        bus_if.cpu_we = 1'b0;
        total++; if (bus_if.cpu_ready !== 1'b0) begin bad++; $display("FAIL cpu_ready_low: got %b want 0", bus_if.cpu_ready); end
        total++; if (bus_if.vram_we !== 1'b0) begin bad++; $display("FAIL cpu_early_we: got %b want 0", bus_if.vram_we); end
        tick();
        total++; if (bus_if.vram_we !== 1'b1) begin bad++; $display("FAIL cpu_we: got %b want 1", bus_if.vram_we); end
        total++; if (bus_if.vram_addr !== 13'h0100) begin bad++; $display("FAIL cpu_addr: got %h want 0100", bus_if.vram_addr); end
        total++; if (bus_if.vram_din !== 12'hF00) begin bad++; $display("FAIL cpu_din: got %h want f00", bus_if.vram_din); end
        total++; if (bus_if.cpu_ready !== 1'b1) begin bad++; $display("FAIL cpu_ready_back: got %b want 1", bus_if.cpu_ready); end
        tick();
        total++; if (bus_if.vram_we !== 1'b0) begin bad++; $display("FAIL cpu_we_once: got %b want 0", bus_if.vram_we); end
    endtask

    task automatic test_clip();
        logic [12:0] exp_addr[4];
        exp_addr[0] = 13'd4718; exp_addr[1] = 13'd4719; exp_addr[2] = 13'd4798; exp_addr[3] = 13'd4799;
        set_fill(78, 58, 5, 5, 12'h0F0);
        bus_if.fill_start = 1'b1;
        tick();
        bus_if.fill_start = 1'b0;
        total++; if (bus_if.fill_busy !== 1'b1 || bus_if.vram_we !== 1'b0) begin bad++; $display("FAIL clip_start: got busy=%b we=%b want 1/0", bus_if.fill_busy, bus_if.vram_we); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus_if.vram_we !== 1'b1 || bus_if.vram_addr !== exp_addr[i] || bus_if.vram_din !== 12'h0F0) begin
                bad++; $display("FAIL clip_write%0d: got we=%b addr=%0d din=%h want 1 %0d 0f0", i, bus_if.vram_we, bus_if.vram_addr, bus_if.vram_din, exp_addr[i]); end
            total++; if (bus_if.fill_done !== (i == 3) || bus_if.fill_busy !== (i != 3)) begin
                bad++; $display("FAIL clip_status%0d: got done=%b busy=%b want %b %b", i, bus_if.fill_done, bus_if.fill_busy, i == 3, i != 3); end
        end
        tick();
        total++; if (bus_if.fill_done !== 1'b0 || bus_if.vram_we !== 1'b0) begin bad++; $display("FAIL clip_after: got done=%b we=%b want 0/0", bus_if.fill_done, bus_if.vram_we); end
    endtask

    task automatic test_full_fill_with_cpu();
        logic [12:0] iss_addr[$];
        logic [11:0] iss_data[$];
        int iss_edge[$];
        int idx, s, d, n, nfill, ncpu, n_during, bad_addr, bad_cpu, max_lat, lat;
        idx = wr_addr.size();
        n = 0;
        d = -1;
        set_fill(0, 0, 80, 60, 12'hABC);
        bus_if.fill_start = 1'b1;
        tick();
        bus_if.fill_start = 1'b0;
        s = cyc;
        for (int i = 1; i < 8000 && d < 0; i++) begin
            if (i % 7 == 3 && bus_if.cpu_ready) begin
                bus_if.cpu_we   = 1'b1;
                bus_if.cpu_addr = 13'((n * 37) % 4800);
                bus_if.cpu_data = 12'(12'h100 + n);
            end
            tick();
            if (bus_if.cpu_we) begin
                iss_addr.push_back(bus_if.cpu_addr);
                iss_data.push_back(bus_if.cpu_data);
                iss_edge.push_back(cyc);
                n++;
            end
            bus_if.cpu_we = 1'b0;
            if (bus_if.fill_done) d = cyc;
        end
        repeat (3) tick();
        total++; if (d < 0) begin bad++; $display("FAIL full_done: got no fill_done within budget want pulse"); end
        nfill = 0; ncpu = 0; n_during = 0; bad_addr = 0; bad_cpu = 0; max_lat = 0;
        for (int j = idx; j < wr_addr.size(); j++) begin
            if (wr_data[j] == 12'hABC) begin
                if (wr_addr[j] !== 13'(nfill)) bad_addr++;
                nfill++;
            end else begin
                if (ncpu < iss_edge.size()) begin
                    if (wr_addr[j] !== iss_addr[ncpu] || wr_data[j] !== iss_data[ncpu]) bad_cpu++;
                    lat = wr_cyc[j] - iss_edge[ncpu];
                    if (lat > max_lat) max_lat = lat;
                    if (lat < 1) bad_cpu++;
                end else begin
                    bad_cpu++;
                end
                if (d >= 0 && wr_cyc[j] <= d) n_during++;
                ncpu++;
            end
        end
        total++; if (nfill != 4800) begin bad++; $display("FAIL full_count: got %0d want 4800", nfill); end
        total++; if (bad_addr != 0) begin bad++; $display("FAIL full_order: got %0d misplaced want 0", bad_addr); end
        total++; if (ncpu != n || n == 0) begin bad++; $display("FAIL full_cpu_count: got %0d want %0d", ncpu, n); end
        total++; if (bad_cpu != 0) begin bad++; $display("FAIL full_cpu_data: got %0d wrong want 0", bad_cpu); end
        total++; if (max_lat > 2) begin bad++; $display("FAIL full_cpu_latency: got %0d want <=2", max_lat); end
        total++; if (d - s != 4800 + n_during) begin bad++; $display("FAIL full_duration: got %0d want %0d", d - s + 1, 4800 + n_during + 1); end
    endtask

    task automatic test_empty_fills();
        int idx;
        for (int k = 0; k < 2; k++) begin
            idx = wr_addr.size();
            if (k == 0) set_fill(0, 0, 0, 5, 12'h123);
            else        set_fill(90, 0, 5, 5, 12'h123);
            bus_if.fill_start = 1'b1;
            tick();
            bus_if.fill_start = 1'b0;
            total++; if (bus_if.fill_done !== 1'b1 || bus_if.fill_busy !== 1'b0 || bus_if.vram_we !== 1'b0) begin
                bad++; $display("FAIL empty%0d_first: got done=%b busy=%b we=%b want 1/0/0", k, bus_if.fill_done, bus_if.fill_busy, bus_if.vram_we); end
            tick();
            total++; if (bus_if.fill_done !== 1'b0 || bus_if.fill_busy !== 1'b0) begin
                bad++; $display("FAIL empty%0d_second: got done=%b busy=%b want 0/0", k, bus_if.fill_done, bus_if.fill_busy); end
            tick();
            total++; if (wr_addr.size() != idx) begin bad++; $display("FAIL empty%0d_writes: got %0d want 0", k, wr_addr.size() - idx); end
        end
    endtask

    task automatic test_abort();
        int idx, nd, seen, nfill, n111, n222, bad_addr;
        idx = wr_addr.size();
        nd = done_cyc.size();
        seen = 0;
        set_fill(5, 5, 10, 10, 12'h555);
        bus_if.fill_start = 1'b1;
        tick();
        bus_if.fill_start = 1'b0;
        for (int i = 0; i < 40 && seen < 15; i++) begin
            tick();
            if (bus_if.vram_we) seen++;
        end
        total++; if (seen != 15) begin bad++; $display("FAIL abort_reach: got %0d want 15", seen); end
        bus_if.fill_abort = 1'b1;
        tick();
        bus_if.fill_abort = 1'b0;
        total++; if (bus_if.vram_we !== 1'b0 || bus_if.fill_busy !== 1'b0 || bus_if.fill_done !== 1'b0) begin
            bad++; $display("FAIL abort_stop: got we=%b busy=%b done=%b want 0/0/0", bus_if.vram_we, bus_if.fill_busy, bus_if.fill_done); end
        bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 13'h0123; bus_if.cpu_data = 12'h111;
        tick();
        total++; if (bus_if.cpu_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus_if.cpu_ready); end
        bus_if.cpu_addr = 13'h0456; bus_if.cpu_data = 12'h222;
        tick();
        bus_if.cpu_we = 1'b0;
        total++; if (bus_if.vram_we !== 1'b1 || bus_if.vram_addr !== 13'h0123 || bus_if.vram_din !== 12'h111) begin
            bad++; $display("FAIL abort_cpu1: got we=%b addr=%h din=%h want 1 0123 111", bus_if.vram_we, bus_if.vram_addr, bus_if.vram_din); end
        repeat (4) tick();
        nfill = 0; n111 = 0; n222 = 0; bad_addr = 0;
        for (int j = idx; j < wr_addr.size(); j++) begin
            if (wr_data[j] == 12'h555) begin
                if (wr_addr[j] !== 13'((5 + nfill / 10) * 80 + 5 + nfill % 10)) bad_addr++;
                nfill++;
            end else if (wr_data[j] == 12'h111) n111++;
            else if (wr_data[j] == 12'h222) n222++;
        end
        total++; if (nfill != 15) begin bad++; $display("FAIL abort_count: got %0d want 15", nfill); end
        total++; if (bad_addr != 0) begin bad++; $display("FAIL abort_addr: got %0d misplaced want 0", bad_addr); end
        total++; if (n111 != 1 || n222 != 0) begin bad++; $display("FAIL abort_cpu: got first=%0d second=%0d want 1 0", n111, n222); end
        total++; if (done_cyc.size() != nd) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", done_cyc.size() - nd); end
    endtask

    task automatic test_async_reset();
        set_fill(0, 0, 10, 10, 12'h777);
        bus_if.fill_start = 1'b1;
        tick();
        bus_if.fill_start = 1'b0;
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1;
        total++; if (bus_if.vram_we !== 1'b0 || bus_if.vram_addr !== 13'h0 || bus_if.vram_din !== 12'h0) begin
            bad++; $display("FAIL arst_vram: got we=%b addr=%h din=%h want 0 0 0", bus_if.vram_we, bus_if.vram_addr, bus_if.vram_din); end
        total++; if (bus_if.fill_busy !== 1'b0 || bus_if.fill_done !== 1'b0 || bus_if.cpu_ready !== 1'b1) begin
            bad++; $display("FAIL arst_ctrl: got busy=%b done=%b ready=%b want 0 0 1", bus_if.fill_busy, bus_if.fill_done, bus_if.cpu_ready); end
        @(posedge clk);
        #1 rstn = 1'b1;
        set_fill(3, 1, 2, 1, 12'h0AB);
        bus_if.fill_start = 1'b1;
        bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 13'h0200; bus_if.cpu_data = 12'h0CD;
        tick();
        bus_if.fill_start = 1'b0;
        bus_if.cpu_we = 1'b0;
        total++; if (bus_if.cpu_ready !== 1'b0 || bus_if.fill_busy !== 1'b1) begin
            bad++; $display("FAIL arst_both_accept: got ready=%b busy=%b want 0 1", bus_if.cpu_ready, bus_if.fill_busy); end
        tick();
        total++; if (bus_if.vram_we !== 1'b1 || bus_if.vram_addr !== 13'h0200 || bus_if.vram_din !== 12'h0CD) begin
            bad++; $display("FAIL arst_tie_cpu: got we=%b addr=%h din=%h want 1 0200 0cd", bus_if.vram_we, bus_if.vram_addr, bus_if.vram_din); end
        tick();
        total++; if (bus_if.vram_we !== 1'b1 || bus_if.vram_addr !== 13'd83 || bus_if.vram_din !== 12'h0AB || bus_if.fill_done !== 1'b0) begin
            bad++; $display("FAIL arst_fill0: got we=%b addr=%0d din=%h done=%b want 1 83 0ab 0", bus_if.vram_we, bus_if.vram_addr, bus_if.vram_din, bus_if.fill_done); end
        tick();
        total++; if (bus_if.vram_we !== 1'b1 || bus_if.vram_addr !== 13'd84 || bus_if.fill_done !== 1'b1 || bus_if.fill_busy !== 1'b0) begin
            bad++; $display("FAIL arst_fill1: got we=%b addr=%0d done=%b busy=%b want 1 84 1 0", bus_if.vram_we, bus_if.vram_addr, bus_if.fill_done, bus_if.fill_busy); end
        tick();
        total++; if (bus_if.vram_we !== 1'b0 || bus_if.fill_done !== 1'b0) begin
            bad++; $display("FAIL arst_end: got we=%b done=%b want 0 0", bus_if.vram_we, bus_if.fill_done); end
    endtask

    initial begin
        bus_if.cpu_we = 1'b0;
        bus_if.cpu_addr = '0;
        bus_if.cpu_data = '0;
        bus_if.fill_start = 1'b0;
        bus_if.fill_abort = 1'b0;
        set_fill(0, 0, 0, 0, 0);
        test_reset();
        test_cpu_single();
        test_clip();
        test_full_fill_with_cpu();
        test_empty_fills();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
